adder_input_packer: RTL

Stream-to-vector packer that feeds the adder tree. It accepts one `BIT_WIDTH` value per handshake and packs `IN_NUM` consecutive values into the `[0:IN_NUM*BIT_WIDTH-1]` vector the tree adder consumes. It holds each packed vector stable until the downstream side accepts it. It also emits `sum_valid`, which marks the cycle in which the adder tree's registered sum for that vector is valid.

---
 rtl/adder_input_packer_if.sv | 32 +++
 rtl/adder_input_packer.sv | 118 +++++++++++
 2 files changed

// File: rtl/adder_input_packer_if.sv
// adder_input_packer_if: stream-in / vector-out handshake bundle for the
// adder tree input packer. The slave modport is the packer's view; the
// master modport is the view of the logic that feeds it and drains it.
interface adder_input_packer_if #(
  parameter int IN_NUM    = -1,
  parameter int BIT_WIDTH = -1
);
  // Clamp so the bundle still elaborates with the -1 parameter defaults.
  localparam int N     = (IN_NUM < 1) ? 1 : IN_NUM;
  localparam int W     = (BIT_WIDTH < 1) ? 1 : BIT_WIDTH;
  localparam int CNT_W = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_value;
  logic               in_last;
  logic [0:N*W-1]     out_values;
  logic [CNT_W-1:0]   out_count;
  logic               out_valid;
  logic               out_ready;
  logic               sum_valid;

  modport master (
    output in_valid, in_value, in_last, out_ready,
    input  in_ready, out_values, out_count, out_valid, sum_valid
  );

  modport slave (
    input  in_valid, in_value, in_last, out_ready,
    output in_ready, out_values, out_count, out_valid, sum_valid
  );
endinterface

// File: rtl/adder_input_packer.sv
// adder_input_packer: packs IN_NUM consecutive BIT_WIDTH beats into the
// [0:IN_NUM*BIT_WIDTH-1] vector consumed by the tree adder (slot 0 on the
// MSB side), holds it until accepted, and delays the transfer event by the
// adder tree latency to produce sum_valid.
// Optional feature: define ADDER_PACKER_FLUSH_EN to let in_last close a
// partial group (zero-padded, out_count = real fill).
module adder_input_packer #(
  parameter int IN_NUM    = -1,
  parameter int BIT_WIDTH = -1
) (
  input logic                  clock,
  input logic                  reset,
  adder_input_packer_if.slave  bus
);
  localparam int N         = (IN_NUM < 1) ? 1 : IN_NUM;
  localparam int W         = (BIT_WIDTH < 1) ? 1 : BIT_WIDTH;
  localparam int ADD_DEPTH = $clog2(N);
  localparam int CNT_W     = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             out_valid_reg;
  logic [0:N*W-1]   out_values_reg;
  logic [CNT_W-1:0] out_count_reg;
  logic [0:N*W-1]   values_next;

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic out_free;
  logic at_last;
  logic completing;

  assign at_last  = (cnt_reg == LAST_SLOT);
  assign out_free = !out_valid_reg | bus.out_ready;
  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid_reg & bus.out_ready;

`ifdef ADDER_PACKER_FLUSH_EN
  // Any beat may complete a group, so a beat can only be taken when the
  // output register is free to receive the result.
  assign in_ready   = out_free;
  assign completing = in_fire & (at_last | bus.in_last);
`else
  // Only the beat landing in the last slot completes; earlier beats just
  // fill the staging slots and can be taken while the output is held.
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign in_ready   = out_free | !at_last;
  assign completing = in_fire & at_last;
`endif

  // Per-slot staging register plus the mux that builds the next vector:
  // staged value below the fill point, live beat at it, zero above it.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);
    logic [W-1:0] fill_reg;

    // Capture the accepted beat into this slot when it is the fill point.
    always_ff @(posedge clock) begin
      if (in_fire && (cnt_reg == SLOT)) begin
        fill_reg <= bus.in_value;
      end
    end

    assign values_next[gi*W +: W] = (SLOT < cnt_reg)  ? fill_reg :
                                    (SLOT == cnt_reg) ? bus.in_value :
                                                        '0;
  end

  // Fill counter and output register; a completing beat reloads the output
  // on the same edge as a transfer so back-to-back vectors have no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_values_reg <= '0;
      out_count_reg  <= '0;
    end else begin
      if (in_fire) begin
        cnt_reg <= completing ? '0 : cnt_reg + CNT_W'(1);
      end
      if (completing) begin
        out_values_reg <= values_next;
        out_count_reg  <= cnt_reg + CNT_W'(1);
        out_valid_reg  <= 1'b1;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // sum_valid follows the transfer event by the adder tree latency.
  if (ADD_DEPTH == 0) begin : g_no_delay
    assign bus.sum_valid = out_fire;
  end else begin : g_delay
    logic [ADD_DEPTH-1:0] delay_reg;

    // Shift the transfer event along; reset cancels pulses in flight.
    always_ff @(posedge clock) begin
      if (reset) begin
        delay_reg <= '0;
      end else begin
        delay_reg[0] <= out_fire;
        for (int i = 1; i < ADD_DEPTH; i++) begin
          delay_reg[i] <= delay_reg[i-1];
        end
      end
    end

    assign bus.sum_valid = delay_reg[ADD_DEPTH-1];
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_values = out_values_reg;
  assign bus.out_count  = out_count_reg;
endmodule
